// File: rtl/dct_coeff_zigzag_quantizer.sv
// Zigzag reader and reciprocal quantizer for completed 8x8 DCT output buffers.
// Streams quantized coefficients over valid/ready and counts buffers awaiting readout.
//
// state | meaning
// IDLE  | no completed buffer pending
// ADDR  | raster address zz[k] presented to coefficient and reciprocal RAMs
// DATA  | RAM outputs captured
// MULT  | product rounded and registered
// OUT   | result offered until handshake
module dct_coeff_zigzag_quantizer #(
  parameter int COEFF_W = 12,
  parameter int RECIP_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         dcts_frontbuffer,
  output logic [1:0]         coeff_rd_buffer,
  output logic [5:0]         coeff_rd_addr,
  input  logic [COEFF_W-1:0] coeff_rd_data,
  input  logic [RECIP_W-1:0] quant_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_coeff,
  output logic [5:0]         out_index,
  output logic               out_last,
  output logic [1:0]         pending_count,
  output logic               overrun
);
  localparam int PW = COEFF_W + RECIP_W + 1;
  localparam logic signed [PW-1:0] HALF = {{(PW-RECIP_W){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_MULT, S_OUT} state_t;
  state_t state, state_nxt;

  logic [1:0] prev_fb, pending_nxt;
  logic [5:0] k, k_nxt;
  logic       done_evt, hs, blk_release, ovr_set;
  logic signed [COEFF_W-1:0] coeff_q;
  logic [RECIP_W-1:0]        recip_q;
  logic signed [PW-1:0]      prod, rounded;
  logic                      unused_bits;

  assign done_evt    = (dcts_frontbuffer != prev_fb);
  assign hs          = (state == S_OUT) && out_ready;
  assign blk_release = hs && (k == 6'd63);
  // 6-bit k wraps 63 -> 0 on the releasing handshake
  assign k_nxt       = hs ? k + 6'd1 : k;

  // Reciprocal is zero-extended so the multiply stays signed x unsigned
  assign prod        = coeff_q * $signed({1'b0, recip_q});
  assign rounded     = prod + HALF;
  assign unused_bits = ^{rounded[PW-1 -: (PW-RECIP_W-COEFF_W)], rounded[RECIP_W-1:0]};

  always_comb begin
    pending_nxt = pending_count;
    ovr_set     = 1'b0;
    if (done_evt && !blk_release) begin
      if (pending_count == 2'd3) ovr_set = 1'b1;
      else pending_nxt = pending_count + 2'd1;
    end else if (blk_release && !done_evt) begin
      pending_nxt = pending_count - 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pending_count != 2'd0) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_DATA;
      S_DATA: state_nxt = S_MULT;
      S_MULT: state_nxt = S_OUT;
      S_OUT:  if (hs) state_nxt = (blk_release && pending_nxt == 2'd0) ? S_IDLE : S_ADDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == S_OUT);
    out_last  = out_valid && (k == 6'd63);
    out_index = k;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_fb         <= 2'd0;
      pending_count   <= 2'd0;
      overrun         <= 1'b0;
      coeff_rd_buffer <= 2'd0;
      k               <= 6'd0;
      coeff_rd_addr   <= 6'd0;
      coeff_q         <= '0;
      recip_q         <= '0;
      out_coeff       <= '0;
    end else begin
      prev_fb       <= dcts_frontbuffer;
      pending_count <= pending_nxt;
      if (ovr_set) overrun <= 1'b1;
      if (blk_release) coeff_rd_buffer <= coeff_rd_buffer + 2'd1;
      k <= k_nxt;
      if (state_nxt == S_ADDR) coeff_rd_addr <= ZZ[k_nxt];
      if (state == S_DATA) begin
        coeff_q <= coeff_rd_data;
        recip_q <= quant_rd_data;
      end
      if (state == S_MULT) out_coeff <= rounded[RECIP_W +: COEFF_W];
    end
  end
endmodule

// File: tb/tb_dct_coeff_zigzag_quantizer.sv
// Directed bench for dct_coeff_zigzag_quantizer with a 1-cycle-latency RAM model.
module tb_dct_coeff_zigzag_quantizer;
  logic        clock;
  logic        reset;
  logic [1:0]  dcts_frontbuffer;
  logic [1:0]  coeff_rd_buffer;
  logic [5:0]  coeff_rd_addr;
  logic [11:0] coeff_rd_data;
  logic [15:0] quant_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coeff;
  logic [5:0]  out_index;
  logic        out_last;
  logic [1:0]  pending_count;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [11:0] mem [4][64];
  logic [15:0] recip_mem [64];
  int zz [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  dct_coeff_zigzag_quantizer #(.COEFF_W(12), .RECIP_W(16)) dut (
    .clock(clock), .reset(reset), .dcts_frontbuffer(dcts_frontbuffer),
    .coeff_rd_buffer(coeff_rd_buffer), .coeff_rd_addr(coeff_rd_addr),
    .coeff_rd_data(coeff_rd_data), .quant_rd_data(quant_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
    .out_index(out_index), .out_last(out_last),
    .pending_count(pending_count), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    coeff_rd_data <= mem[coeff_rd_buffer][coeff_rd_addr];
    quant_rd_data <= recip_mem[coeff_rd_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    checks++;
    if ({out_valid, out_coeff, out_index, out_last, coeff_rd_addr, coeff_rd_buffer, pending_count, overrun} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b coeff=%0h idx=%0d last=%0b addr=%0d buf=%0d pend=%0d ovr=%0b, all should be 0",
               out_valid, out_coeff, out_index, out_last, coeff_rd_addr, coeff_rd_buffer, pending_count, overrun);
    end
    reset = 1'b0;
    cyc(3);
    checks++;
    if (out_valid !== 1'b0 || pending_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: valid=%0b pend=%0d, expected 0 0", out_valid, pending_count);
    end
  endtask

  task automatic test_single_block();
    logic [11:0] exp;
    out_ready = 1'b1;
    dcts_frontbuffer = 2'd1;
    cyc(1);
    checks++;
    if (pending_count !== 2'd1) begin
      errors++;
      $display("FAIL single_pending_up: pend=%0d expected 1", pending_count);
    end
    cyc(3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early: valid=%0b expected 0 at n+4", out_valid);
    end
    cyc(1);
    for (int k = 0; k < 64; k++) begin
      exp = 12'((zz[k] + 1) / 2);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 6'(k) || out_coeff !== exp ||
          coeff_rd_addr !== 6'(zz[k]) || out_last !== (k == 63)) begin
        errors++;
        $display("FAIL single_k%0d: valid=%0b idx=%0d coeff=%0d addr=%0d last=%0b, expected 1 %0d %0d %0d %0b",
                 k, out_valid, out_index, out_coeff, coeff_rd_addr, out_last, k, exp, zz[k], (k == 63));
      end
      if (k < 63) cyc(4);
    end
    cyc(1);
    checks++;
    if (pending_count !== 2'd0 || coeff_rd_buffer !== 2'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: pend=%0d buf=%0d valid=%0b, expected 0 1 0", pending_count, coeff_rd_buffer, out_valid);
    end
  endtask

  task automatic test_rounding();
    logic [11:0] rin  [5];
    logic [11:0] rexp [5];
    logic [11:0] exp;
    int w;
    rin  = '{12'd5, 12'hFFD, 12'hFFF, 12'd2047, 12'h800};
    rexp = '{12'd3, 12'hFFF, 12'd0, 12'd1024, 12'hC00};
    for (int i = 0; i < 5; i++) mem[1][zz[i]] = rin[i];
    out_ready = 1'b1;
    dcts_frontbuffer = 2'd2;
    for (int k = 0; k < 64; k++) begin
      w = 0;
      while (out_valid !== 1'b1 && w < 20) begin cyc(1); w++; end
      exp = (k < 5) ? rexp[k] : 12'((zz[k] + 64 + 1) / 2);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 6'(k) || out_coeff !== exp) begin
        errors++;
        $display("FAIL round_k%0d: valid=%0b idx=%0d coeff=%0h, expected 1 %0d %0h", k, out_valid, out_index, out_coeff, k, exp);
      end
      cyc(1);
    end
    for (int i = 0; i < 5; i++) mem[1][zz[i]] = 12'(zz[i] + 64);
    checks++;
    if (pending_count !== 2'd0 || coeff_rd_buffer !== 2'd2) begin
      errors++;
      $display("FAIL round_release: pend=%0d buf=%0d, expected 0 2", pending_count, coeff_rd_buffer);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp;
    logic [11:0] held;
    int w;
    out_ready = 1'b1;
    dcts_frontbuffer = 2'd3;
    for (int k = 0; k < 64; k++) begin
      w = 0;
      while (out_valid !== 1'b1 && w < 20) begin cyc(1); w++; end
      exp = 12'((zz[k] + 128 + 1) / 2);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 6'(k) || out_coeff !== exp) begin
        errors++;
        $display("FAIL bp_k%0d: valid=%0b idx=%0d coeff=%0d, expected 1 %0d %0d", k, out_valid, out_index, out_coeff, k, exp);
      end
      if (k == 5) begin
        out_ready = 1'b0;
        held = out_coeff;
        for (int c = 0; c < 10; c++) begin
          cyc(1);
          checks++;
          if (out_valid !== 1'b1 || out_index !== 6'd5 || out_coeff !== held) begin
            errors++;
            $display("FAIL bp_hold_c%0d: valid=%0b idx=%0d coeff=%0d, expected 1 5 %0d", c, out_valid, out_index, out_coeff, held);
          end
        end
        out_ready = 1'b1;
      end
      cyc(1);
    end
    checks++;
    if (pending_count !== 2'd0 || coeff_rd_buffer !== 2'd3) begin
      errors++;
      $display("FAIL bp_release: pend=%0d buf=%0d, expected 0 3", pending_count, coeff_rd_buffer);
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    dcts_frontbuffer = 2'd0; cyc(1);
    dcts_frontbuffer = 2'd1; cyc(1);
    dcts_frontbuffer = 2'd2; cyc(1);
    checks++;
    if (pending_count !== 2'd3 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_three: pend=%0d ovr=%0b, expected 3 0", pending_count, overrun);
    end
    dcts_frontbuffer = 2'd3; cyc(1);
    checks++;
    if (pending_count !== 2'd3 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_fourth: pend=%0d ovr=%0b, expected 3 1", pending_count, overrun);
    end
    cyc(5);
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b1 || out_index !== 6'd0) begin
      errors++;
      $display("FAIL overrun_sticky: ovr=%0b valid=%0b idx=%0d, expected 1 1 0", overrun, out_valid, out_index);
    end
  endtask

  task automatic test_wrap_simultaneous();
    int blk_buf  [5] = '{3, 0, 1, 2, 3};
    int exp_buf  [5] = '{0, 1, 2, 3, 0};
    int exp_pend [5] = '{2, 1, 1, 0, 0};
    logic [11:0] exp;
    int w;
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      if (b == 4) dcts_frontbuffer = 2'd1;
      for (int k = 0; k < 64; k++) begin
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin cyc(1); w++; end
        exp = 12'((zz[k] + 64 * blk_buf[b] + 1) / 2);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 6'(k) || out_coeff !== exp) begin
          errors++;
          $display("FAIL wrap_b%0d_k%0d: valid=%0b idx=%0d coeff=%0d, expected 1 %0d %0d", b, k, out_valid, out_index, out_coeff, k, exp);
        end
        if (b == 2 && k == 63) dcts_frontbuffer = 2'd0;
        cyc(1);
      end
      checks++;
      if (coeff_rd_buffer !== 2'(exp_buf[b]) || pending_count !== 2'(exp_pend[b])) begin
        errors++;
        $display("FAIL wrap_release_b%0d: buf=%0d pend=%0d, expected %0d %0d", b, coeff_rd_buffer, pending_count, exp_buf[b], exp_pend[b]);
      end
      if (b == 2) begin
        cyc(3);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 6'd0) begin
          errors++;
          $display("FAIL simul_restart: valid=%0b idx=%0d, expected 1 0", out_valid, out_index);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b1;
    dcts_frontbuffer = 2'd2;
    for (int k = 0; k < 20; k++) begin
      w = 0;
      while (out_valid !== 1'b1 && w < 20) begin cyc(1); w++; end
      checks++;
      if (out_valid !== 1'b1 || out_index !== 6'(k)) begin
        errors++;
        $display("FAIL rmid_k%0d: valid=%0b idx=%0d, expected 1 %0d", k, out_valid, out_index, k);
      end
      if (k < 19) cyc(1);
    end
    cyc(3);
    checks++;
    if (out_valid !== 1'b0 || coeff_rd_addr !== 6'(zz[20]) || overrun !== 1'b1) begin
      errors++;
      $display("FAIL rmid_premult: valid=%0b addr=%0d ovr=%0b, expected 0 %0d 1", out_valid, coeff_rd_addr, overrun, zz[20]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_coeff, out_index, out_last, coeff_rd_addr, coeff_rd_buffer, pending_count, overrun} !== 31'd0) begin
      errors++;
      $display("FAIL rmid_async: valid=%0b coeff=%0h idx=%0d last=%0b addr=%0d buf=%0d pend=%0d ovr=%0b, all should be 0",
               out_valid, out_coeff, out_index, out_last, coeff_rd_addr, coeff_rd_buffer, pending_count, overrun);
    end
    dcts_frontbuffer = 2'd0;
    cyc(2);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      checks++;
      if (out_valid !== 1'b0 || pending_count !== 2'd0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL rmid_after_c%0d: valid=%0b pend=%0d ovr=%0b, expected 0 0 0", c, out_valid, pending_count, overrun);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    dcts_frontbuffer = 2'd0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++) mem[b][a] = 12'(a + 64 * b);
    for (int a = 0; a < 64; a++) recip_mem[a] = 16'h8000;
    test_reset();
    test_single_block();
    test_rounding();
    test_backpressure();
    test_overrun();
    test_wrap_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
